// File: rtl/avalon_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master between the fetch (I) and
// load/store (D) paths; master signals come only from registers and hold across stalls.
module avalon_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   i_address,
    input  logic                i_read,
    input  logic                i_write,
    input  logic [DATA_W-1:0]   i_writedata,
    input  logic [DATA_W/8-1:0] i_byteenable,
    output logic                i_waitrequest,
    output logic [DATA_W-1:0]   i_readdata,

    input  logic [ADDR_W-1:0]   d_address,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W-1:0]   d_writedata,
    input  logic [DATA_W/8-1:0] d_byteenable,
    output logic                d_waitrequest,
    output logic [DATA_W-1:0]   d_readdata,

    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic                waitrequest,
    input  logic [DATA_W-1:0]   readdata
);
    localparam int BE_W    = DATA_W / 8;
    localparam int NUM_REQ = 2;
    localparam int REQ_I   = 0;
    localparam int REQ_D   = 1;

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    state_t state;
    logic   last_grant;   // 1: D was granted last, so I wins the next tie

    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0][BE_W-1:0]   req_be;
    logic [NUM_REQ-1:0]             req_rd;
    logic [NUM_REQ-1:0]             req_wr;
    logic [NUM_REQ-1:0]             req_any;
    logic [NUM_REQ-1:0]             req_rd_only;
    logic [NUM_REQ-1:0]             granted;
    logic [NUM_REQ-1:0]             done;
    logic                           pick;

    assign req_addr  = {d_address, i_address};
    assign req_wdata = {d_writedata, i_writedata};
    assign req_be    = {d_byteenable, i_byteenable};
    assign req_rd    = {d_read, i_read};
    assign req_wr    = {d_write, i_write};
    assign granted   = {state == GRANT_D, state == GRANT_I};

    // Write takes precedence when a requester raises both strobes.
    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
            assign req_any[g]     = req_rd[g] | req_wr[g];
            assign req_rd_only[g] = req_rd[g] & ~req_wr[g];
            assign done[g]        = granted[g] & ~waitrequest;
        end
    endgenerate

    assign pick = req_any[REQ_D] & (~req_any[REQ_I] | ~last_grant);

    assign i_waitrequest = ~done[REQ_I];
    assign d_waitrequest = ~done[REQ_D];
    assign i_readdata    = readdata;
    assign d_readdata    = readdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            address    <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            writedata  <= '0;
            byteenable <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_any) begin
                        state      <= pick ? GRANT_D : GRANT_I;
                        address    <= req_addr[pick];
                        writedata  <= req_wdata[pick];
                        byteenable <= req_be[pick];
                        write      <= req_wr[pick];
                        read       <= req_rd_only[pick];
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (!waitrequest) begin
                        state      <= IDLE;
                        last_grant <= (state == GRANT_D);
                        read       <= 1'b0;
                        write      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Bench for avalon_bus_arbiter: vector table + hand sequences, completions checked
// against a scoreboard of expected transfers by a per-cycle monitor.
module tb_avalon_bus_arbiter;
    logic        clk;
    logic        reset;
    logic [31:0] i_address, d_address, i_writedata, d_writedata;
    logic        i_read, i_write, d_read, d_write;
    logic [3:0]  i_byteenable, d_byteenable;
    logic        i_waitrequest, d_waitrequest;
    logic [31:0] i_readdata, d_readdata;
    logic [31:0] address, writedata, readdata;
    logic        read, write, waitrequest;
    logic [3:0]  byteenable;

    avalon_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_address(i_address), .i_read(i_read), .i_write(i_write),
        .i_writedata(i_writedata), .i_byteenable(i_byteenable),
        .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable),
        .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
        .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .waitrequest(waitrequest), .readdata(readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          stalls;
        logic [31:0] rdata;
        int          exp_lat;   // grant cycles until completion
    } vec_t;

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    bit   grant_log[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   stall_budget = 0;
    bit   done_i, done_d;
    bit   prev_stall = 0;
    logic [31:0] prev_addr, prev_wdata;
    logic [3:0]  prev_be;
    logic [1:0]  prev_rw;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_reqs();
        i_read = 0; i_write = 0; i_address = '0; i_writedata = '0; i_byteenable = '0;
        d_read = 0; d_write = 0; d_address = '0; d_writedata = '0; d_byteenable = '0;
    endtask

    // One cycle: slave answers at the falling edge, then the monitor checks.
    task automatic tick();
        exp_t e;
        bit   rst_seen;
        bit   got_d;
        @(negedge clk);
        rst_seen = reset;
        if ((read || write) && stall_budget > 0) begin
            waitrequest = 1'b1;
            stall_budget--;
        end else begin
            waitrequest = 1'b0;
        end
        #1;
        if (prev_stall && !rst_seen) begin
            chk("hold_addr", address, prev_addr);
            chk("hold_strobe", 32'({read, write}), 32'(prev_rw));
            chk("hold_wdata", writedata, prev_wdata);
            chk("hold_be", 32'(byteenable), 32'(prev_be));
        end
        if ((read || write) && !waitrequest) begin
            chk("one_wait_low", 32'(i_waitrequest ^ d_waitrequest), 32'd1);
            got_d = !d_waitrequest;
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL sb_empty: unexpected completion at address %h", address);
            end else begin
                e = sb.pop_front();
                chk("grantee", 32'(got_d), 32'(e.is_d));
                chk("addr", address, e.addr);
                chk("strobe", 32'({read, write}), 32'({!e.wr, e.wr}));
                chk("be", 32'(byteenable), 32'(e.be));
                if (e.wr) chk("wdata", writedata, e.wdata);
                else      chk("rdata", got_d ? d_readdata : i_readdata, e.rdata);
            end
            grant_log.push_back(got_d);
            if (got_d) done_d = 1; else done_i = 1;
        end else begin
            chk("wait_hi", 32'({i_waitrequest, d_waitrequest}), 32'd3);
        end
        prev_stall = (read || write) && waitrequest;
        prev_addr  = address;
        prev_wdata = writedata;
        prev_be    = byteenable;
        prev_rw    = {read, write};
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        bit fin;
        clear_reqs();
        if (v.is_d) begin
            d_read = v.rd; d_write = v.wr; d_address = v.addr;
            d_writedata = v.wdata; d_byteenable = v.be;
        end else begin
            i_read = v.rd; i_write = v.wr; i_address = v.addr;
            i_writedata = v.wdata; i_byteenable = v.be;
        end
        readdata = v.rdata;
        stall_budget = v.stalls;
        sb.push_back('{v.is_d, v.wr, v.addr, v.wdata, v.be, v.rdata});
        done_i = 0; done_d = 0;
        tick();
        chk($sformatf("v%0d_latency", idx), 32'(read | write), 32'd1);
        cyc = 1;
        fin = v.is_d ? done_d : done_i;
        while (!fin && cyc < 40) begin
            tick();
            cyc++;
            fin = v.is_d ? done_d : done_i;
        end
        chk($sformatf("v%0d_done", idx), 32'(fin), 32'd1);
        chk($sformatf("v%0d_cycles", idx), 32'(cyc), 32'(v.exp_lat));
        clear_reqs();
        tick();
        chk($sformatf("v%0d_clear", idx), 32'({read, write}), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        //            is_d rd wr addr          wdata         be       st rdata         lat
        vecs[0] = '{1'b0, 1, 0, 32'hBFC00000, 32'h0,        4'b1111, 0, 32'h8C010064, 1};
        vecs[1] = '{1'b1, 0, 1, 32'd200,      32'd404,      4'b1111, 3, 32'h0,        4};
        vecs[2] = '{1'b1, 1, 1, 32'h10,       32'hDEADBEEF, 4'b0011, 0, 32'h0,        1};
        vecs[3] = '{1'b1, 1, 0, 32'h10000004, 32'h0,        4'b1100, 1, 32'h12345678, 2};
        vecs[4] = '{1'b0, 0, 1, 32'h20,       32'hA5A5A5A5, 4'b0001, 2, 32'h0,        3};
        vecs[5] = '{1'b0, 1, 0, 32'hFFFFFFFC, 32'h0,        4'b1111, 0, 32'hFFFFFFFF, 1};

        reset = 1'b1;
        clear_reqs();
        waitrequest = 1'b0;
        readdata = '0;
        tick();
        tick();
        chk("rst_read", 32'(read), 32'd0);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_addr", address, 32'd0);
        chk("rst_wdata", writedata, 32'd0);
        chk("rst_be", 32'(byteenable), 32'd0);
        chk("rst_i_wait", 32'(i_waitrequest), 32'd1);
        chk("rst_d_wait", 32'(d_waitrequest), 32'd1);
        reset = 1'b0;

        // Tie straight after reset: fetch first, then alternate.
        i_read = 1; i_address = 32'h100; i_byteenable = 4'hF;
        d_read = 1; d_address = 32'h200; d_byteenable = 4'hF;
        readdata = 32'h55;
        stall_budget = 0;
        sb.push_back('{1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 32'h55});
        sb.push_back('{1'b1, 1'b0, 32'h200, 32'h0, 4'hF, 32'h55});
        sb.push_back('{1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 32'h55});
        grant_log.delete();
        n = 0;
        while (grant_log.size() < 3 && n < 30) begin
            tick();
            n++;
        end
        clear_reqs();
        chk("tie_count", 32'(grant_log.size()), 32'd3);
        chk("tie_cycles", 32'(n), 32'd5);
        if (grant_log.size() == 3) begin
            chk("tie_1st", 32'(grant_log[0]), 32'd0);
            chk("tie_2nd", 32'(grant_log[1]), 32'd1);
            chk("tie_3rd", 32'(grant_log[2]), 32'd0);
        end
        tick();
        chk("tie_clear", 32'({read, write}), 32'd0);

        foreach (vecs[k]) run_vec(k, vecs[k]);

        // Reset lands in the second stall cycle of a fetch.
        clear_reqs();
        i_read = 1; i_address = 32'h400; i_byteenable = 4'hF;
        readdata = 32'h0BADF00D;
        stall_budget = 10;
        sb.push_back('{1'b0, 1'b0, 32'h400, 32'h0, 4'hF, 32'h0BADF00D});
        done_i = 0; done_d = 0;
        tick();
        chk("mid_grant_up", 32'(read), 32'd1);
        tick();
        chk("mid_stall", 32'(waitrequest), 32'd1);
        reset = 1'b1;
        stall_budget = 0;
        tick();
        chk("mid_rst_strobe", 32'({read, write}), 32'd0);
        chk("mid_rst_addr", address, 32'd0);
        chk("mid_rst_no_done", 32'(done_i), 32'd0);
        reset = 1'b0;
        tick();
        chk("mid_retry_done", 32'(done_i), 32'd1);
        clear_reqs();
        tick();
        chk("mid_clear", 32'({read, write}), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
